// File: rtl/decoupled_skid_buffer.sv
// Two-entry ready/valid register slice: payload, valid and ready are all driven from flops,
// so no combinational path crosses the block while one beat per cycle is still sustained.
module decoupled_skid_buffer #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic [1:0]       count
);

  // Encoding is {skid_v, main_v}, so the handshake outputs fall straight out of the state bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] main_d_r;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] skid_d_r;
  logic [WIDTH-1:0] skid_d_s;
  logic             enq_fire_s;
  logic             deq_fire_s;

  assign deq_valid  = state_r[0];
  assign enq_ready  = ~state_r[1];
  assign deq_bits   = main_d_r;
  assign count      = {1'b0, state_r[0]} + {1'b0, state_r[1]};
  assign enq_fire_s = enq_valid & ~state_r[1];
  assign deq_fire_s = deq_ready & state_r[0];

  // Next-state and payload steering.
  always_comb begin
    state_s  = state_r;
    main_d_s = main_d_r;
    skid_d_s = skid_d_r;
    case (state_r)
      EMPTY: begin
        if (enq_fire_s) begin
          state_s  = ONE;
          main_d_s = enq_bits;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (enq_fire_s && deq_fire_s) begin
          state_s  = ONE;
          main_d_s = enq_bits;
        end else if (enq_fire_s) begin
          state_s  = FULL;
          skid_d_s = enq_bits;
        end else if (deq_fire_s) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      FULL: begin
        if (deq_fire_s) begin
          state_s  = ONE;
          main_d_s = skid_d_r;
        end else begin
          state_s = FULL;
        end
      end
      // skid-only occupancy is unreachable; fall back to empty if it ever appears
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // State and payload registers; reset wins over any fire in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= EMPTY;
      main_d_r <= RESET_DATA;
      skid_d_r <= RESET_DATA;
    end else begin
      state_r  <= state_s;
      main_d_r <= main_d_s;
      skid_d_r <= skid_d_s;
    end
  end

endmodule
